datamem_arbiter: RTL and testbench
==================================

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, requester and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write and read data width.
REQ-003 SHALL have parameter PRIO_MODE, default 0, where 0 selects round-robin and 1 selects fixed priority with port 0 winning.
REQ-004 SHALL have parameter MAX_WAIT, default 16, the port-1 starvation limit in cycles, used only when PRIO_MODE=1.
REQ-005 SHALL have port aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 SHALL have pN_req, input, 1 bit, for N=0,1, meaning requester N has a pending access.
REQ-008 SHALL have pN_gnt, output, 1 bit, meaning requester N's access is accepted this cycle (pN_req & pN_gnt).
REQ-009 SHALL have pN_addr, input, ADDR_WIDTH bits, the access address.
REQ-010 SHALL have pN_we, input, 1 bit, where 1 means write and 0 means read.
REQ-011 SHALL have pN_func3, input, 3 bits, the RISC-V load/store size code, passed through unmodified.
REQ-012 SHALL have pN_wdata, input, DATA_WIDTH bits, the write data.
REQ-013 SHALL have pN_rvalid, output, 1 bit, meaning the response is valid (read data or write completion).
REQ-014 SHALL have pN_rdata, output, DATA_WIDTH bits, the read data, which is 0 for writes.
REQ-015 SHALL have pN_rready, input, 1 bit, meaning requester N accepts the response.
REQ-016 SHALL have mem_addr, mem_wdata, mem_func3 and mem_write_en as outputs, of ADDR_WIDTH, DATA_WIDTH, 3 and 1 bits, driving the datamem ports.
REQ-017 SHALL have mem_rdata, input, DATA_WIDTH bits, datamem read data, valid one cycle after mem_addr is presented.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, CAPTURE and RESP; at most one transaction is in flight.
REQ-019 SHALL assert pN_gnt combinationally only in IDLE, only for the arbitration winner, and only when pN_req=1; at most one gnt is high per cycle.
REQ-020 SHALL, when both ports request with PRIO_MODE=0, grant the port not granted last; the last-grant register resets to 1, so port 0 wins the first tie.
REQ-021 SHALL, with PRIO_MODE=1, grant port 0 on a tie unless wait_cnt>=MAX_WAIT, in which case port 1 wins.
REQ-022 SHALL keep wait_cnt as an 8-bit counter that increments on every cycle with p1_req=1 and no p1 grant, saturates at 255, and clears on a p1 grant or while p1_req=0.
REQ-023 SHALL, on accept, register addr/we/func3/wdata and the granted port ID, and move to ACCESS on the next edge.
REQ-024 SHALL, in ACCESS, drive mem_addr, mem_func3 and mem_wdata from the registers; mem_write_en=we for exactly this one cycle; next state is CAPTURE.
REQ-025 SHALL, in CAPTURE, keep mem_addr driven, register mem_rdata on a read or 0 on a write, and move to RESP.
REQ-026 SHALL, in RESP, hold rvalid=1 and stable rdata on the owning port only until rready=1, then return to IDLE on that edge.
REQ-027 SHALL keep minimum transaction latency at accept->rvalid = 3 cycles and back-to-back throughput at one transaction per 4 cycles, with no accept in the RESP->IDLE cycle.
REQ-028 SHALL hold mem_write_en=0 in every state except ACCESS-with-write; mem_addr, mem_wdata and mem_func3 hold their last values outside ACCESS/CAPTURE.
REQ-029 SHALL treat req deasserted before grant as a legal withdrawal with nothing recorded; req held through a busy period is served in the next IDLE.
REQ-030 SHALL ignore the non-owning port's rready, and keep its rvalid=0 at all times.
REQ-031 SHALL not check func3 or address alignment; these pass to datamem unchanged.

Reset
REQ-032 SHALL, on aresetn=0 asynchronously, enter IDLE and drive all outputs to 0: gnt, rvalid, rdata, mem_addr, mem_wdata, mem_func3, mem_write_en; wait_cnt is 0 and last-grant is 1.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction with no response; a write in ACCESS has mem_write_en deasserted immediately, with no glitch extension.
REQ-034 SHALL grant no request before the first rising edge after aresetn deasserts.

Verification
REQ-035 SHALL cover a single write: p0 writes 0xDEADBEEF to 0x10 with func3=010 -> mem_write_en high for exactly 1 cycle, p0_rvalid 3 cycles after accept, p0_rdata=0.
REQ-036 SHALL cover read-back: p1 reads 0x10 -> p1_rvalid with p1_rdata=0xDEADBEEF, p1_rready held 0 for 5 cycles, rdata stable throughout.
REQ-037 SHALL cover a round-robin tie: PRIO_MODE=0 with both req held continuously for 4 transactions -> grant order p0,p1,p0,p1.
REQ-038 SHALL cover starvation: PRIO_MODE=1, MAX_WAIT=16, p0 and p1 req held -> p1 granted within the first IDLE with wait_cnt>=16, then wait_cnt=0.
REQ-039 SHALL cover reset mid-op: aresetn asserted during ACCESS of a write -> mem_write_en drops the same cycle, state IDLE, no rvalid after release.

Source files
------------

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of a single-cycle-latency data memory; one transaction in flight.
// state   | meaning
// IDLE    | arbitrate, accept a request and latch its fields
// ACCESS  | present the access to datamem, write strobe for writes
// CAPTURE | latch mem_rdata (or 0 for writes)
// RESP    | hold rvalid/rdata on the owning port until rready
module datamem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PRIO_MODE  = 0,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  p0_req,
    output logic                  p0_gnt,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_we,
    input  logic [2:0]            p0_func3,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p0_rready,

    input  logic                  p1_req,
    output logic                  p1_gnt,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_we,
    input  logic [2:0]            p1_func3,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    input  logic                  p1_rready,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_func3,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    started_q, started_d;
    logic                    last_q, last_d;
    logic                    owner_q, owner_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]              func3_q, func3_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic pick1;
    logic gnt0;
    logic gnt1;
    logic rready_own;

    always_comb begin
        pick1 = p1_req;
        if (p0_req && p1_req) begin
            if (PRIO_MODE == 0) begin
                pick1 = ~last_q;
            end else begin
                pick1 = (int'(wait_cnt_q) >= MAX_WAIT);
            end
        end
        // started_q keeps grants off until the first edge after reset release
        gnt0 = started_q && (state_q == IDLE) && p0_req && !pick1;
        gnt1 = started_q && (state_q == IDLE) && p1_req && pick1;
        rready_own = owner_q ? p1_rready : p0_rready;
    end

    always_comb begin
        state_d    = state_q;
        started_d  = 1'b1;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        func3_d    = func3_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;

        if (!p1_req || gnt1) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = ACCESS;
                    owner_d = gnt1;
                    last_d  = gnt1;
                    addr_d  = gnt1 ? p1_addr  : p0_addr;
                    wdata_d = gnt1 ? p1_wdata : p0_wdata;
                    func3_d = gnt1 ? p1_func3 : p0_func3;
                    we_d    = gnt1 ? p1_we    : p0_we;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rdata_d = we_q ? '0 : mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (rready_own) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            started_q  <= 1'b0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            wait_cnt_q <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            func3_q    <= 3'd0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= started_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            func3_q    <= func3_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
        end
    end

    // Latched fields only change on accept, so they hold outside ACCESS/CAPTURE.
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_func3    = func3_q;
    assign mem_write_en = (state_q == ACCESS) && we_q;

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = (state_q == RESP) && !owner_q;
    assign p1_rvalid = (state_q == RESP) && owner_q;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench: round-robin instance with a small memory model, plus a fixed-priority instance for starvation.
module tb_datamem_arbiter;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        p0_req, p0_gnt, p0_we, p0_rvalid, p0_rready;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [2:0]  p0_func3;
    logic        p1_req, p1_gnt, p1_we, p1_rvalid, p1_rready;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [2:0]  p1_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;
    logic        mem_write_en;

    logic        b_p0_req, b_p0_gnt, b_p0_rvalid, b_p1_req, b_p1_gnt, b_p1_rvalid;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_mem_func3;
    logic        b_mem_write_en;

    datamem_arbiter #(.PRIO_MODE(0)) dut_rr (
        .aclk(aclk), .aresetn(aresetn),
        .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_addr(p0_addr), .p0_we(p0_we),
        .p0_func3(p0_func3), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_addr(p1_addr), .p1_we(p1_we),
        .p1_func3(p1_func3), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_rready(p1_rready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
        .mem_write_en(mem_write_en), .mem_rdata(mem_rdata)
    );

    datamem_arbiter #(.PRIO_MODE(1), .MAX_WAIT(16)) dut_fp (
        .aclk(aclk), .aresetn(aresetn),
        .p0_req(b_p0_req), .p0_gnt(b_p0_gnt), .p0_addr(32'h40), .p0_we(1'b0),
        .p0_func3(3'b010), .p0_wdata(32'h0), .p0_rvalid(b_p0_rvalid),
        .p0_rdata(b_p0_rdata), .p0_rready(1'b1),
        .p1_req(b_p1_req), .p1_gnt(b_p1_gnt), .p1_addr(32'h44), .p1_we(1'b0),
        .p1_func3(3'b010), .p1_wdata(32'h0), .p1_rvalid(b_p1_rvalid),
        .p1_rdata(b_p1_rdata), .p1_rready(1'b1),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_func3(b_mem_func3),
        .mem_write_en(b_mem_write_en), .mem_rdata(b_mem_rdata)
    );

    // datamem stand-in: read data valid one cycle after the address
    logic [31:0] mem [16];
    always @(posedge aclk) begin
        if (mem_write_en) mem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[5:2]];
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
        logic [31:0] exp_rdata;
        int          hold;
    } vec_t;

    vec_t vecs[5];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_req();
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic txn(input vec_t v);
        int n;
        logic own_rv, oth_rv;
        logic [31:0] own_rd;
        if (v.port == 1'b0) begin
            p0_req = 1'b1; p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata; p0_func3 = v.func3;
        end else begin
            p1_req = 1'b1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata; p1_func3 = v.func3;
        end
        n = 0;
        @(negedge aclk);
        while (!(p0_gnt || p1_gnt) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) begin
            chk("gnt_timeout", 64'(1), 64'(0));
            drop_req();
            return;
        end
        chk("gnt_port", 64'({p1_gnt, p0_gnt}), 64'(v.port ? 2'b10 : 2'b01));
        @(posedge aclk);
        #1 drop_req();
        @(negedge aclk);
        chk("access_we", 64'(mem_write_en), 64'(v.we));
        chk("access_addr", 64'(mem_addr), 64'(v.addr));
        chk("access_wdata", 64'(mem_wdata), 64'(v.wdata));
        chk("access_func3", 64'(mem_func3), 64'(v.func3));
        @(negedge aclk);
        chk("capture_we", 64'(mem_write_en), 64'(0));
        chk("capture_addr", 64'(mem_addr), 64'(v.addr));
        chk("capture_rvalid", 64'(p0_rvalid | p1_rvalid), 64'(0));
        // the other port's rready must not release the response
        if (v.port) p0_rready = 1'b1; else p1_rready = 1'b1;
        for (int i = 0; i <= v.hold; i++) begin
            if (i != 0) @(negedge aclk);
            own_rv = v.port ? p1_rvalid : p0_rvalid;
            oth_rv = v.port ? p0_rvalid : p1_rvalid;
            own_rd = v.port ? p1_rdata : p0_rdata;
            if (i == 0) @(negedge aclk);
            own_rv = v.port ? p1_rvalid : p0_rvalid;
            oth_rv = v.port ? p0_rvalid : p1_rvalid;
            own_rd = v.port ? p1_rdata : p0_rdata;
            chk("resp_rvalid", 64'(own_rv), 64'(1));
            chk("resp_other_rvalid", 64'(oth_rv), 64'(0));
            chk("resp_rdata", 64'(own_rd), 64'(v.exp_rdata));
        end
        if (v.port) p1_rready = 1'b1; else p0_rready = 1'b1;
        @(posedge aclk);
        #1;
        p0_rready = 1'b0;
        p1_rready = 1'b0;
        @(negedge aclk);
        chk("post_rvalid", 64'(p0_rvalid | p1_rvalid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic order[4];
        int   gcyc[4];
        int   k;
        int   exp_st[10];
        logic st_port[10];
        int   st_cyc[10];

        vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 5};
        vecs[2] = '{1'b1, 1'b1, 32'h14, 32'h12345678, 3'b001, 32'h0,        1};
        vecs[3] = '{1'b0, 1'b0, 32'h14, 32'h0,        3'b100, 32'h12345678, 2};
        vecs[4] = '{1'b0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0};
        exp_st = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_func3 = 3'd0; p0_rready = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_func3 = 3'd0; p1_rready = 1'b0;
        b_p0_req = 1'b0; b_p1_req = 1'b0; b_mem_rdata = 32'h0;

        #23;
        chk("rst_gnt", 64'(p0_gnt | p1_gnt), 64'(0));
        chk("rst_rvalid", 64'(p0_rvalid | p1_rvalid), 64'(0));
        chk("rst_mem_outs", 64'({mem_addr, mem_wdata} | 64'(mem_func3) | 64'(mem_write_en)), 64'(0));
        chk("rst_rdata", 64'(p0_rdata | p1_rdata), 64'(0));

        @(posedge aclk);
        #2 aresetn = 1'b1;
        #1 chk("no_gnt_before_edge", 64'(p0_gnt), 64'(0));
        @(posedge aclk);
        #1 chk("gnt_after_edge", 64'(p0_gnt), 64'(1));
        p0_req = 1'b0;
        #1 chk("withdraw_gnt", 64'(p0_gnt), 64'(0));
        repeat (4) @(negedge aclk);
        chk("withdraw_no_resp", 64'(p0_rvalid | p1_rvalid), 64'(0));

        // round-robin tie: both held for four transactions
        @(posedge aclk);
        #1;
        p0_req = 1'b1; p1_req = 1'b1; p0_rready = 1'b1; p1_rready = 1'b1;
        p0_addr = 32'h20; p1_addr = 32'h24;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge aclk);
            if (p0_gnt && p1_gnt) chk("tie_one_gnt", 64'(2'b11), 64'(2'b01));
            if (p0_gnt || p1_gnt) begin
                order[k] = p1_gnt;
                gcyc[k] = cyc;
                k++;
            end
        end
        chk("tie_count", 64'(k), 64'(4));
        @(posedge aclk);
        #1 drop_req();
        if (k == 4) begin
            for (int i = 0; i < 4; i++) chk("tie_order", 64'(order[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk("tie_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(4));
        end
        repeat (6) @(posedge aclk);
        #1;
        p0_rready = 1'b0;
        p1_rready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1 txn(vecs[i]);
        end

        // reset in the ACCESS cycle of a write
        @(posedge aclk);
        #1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h18; p0_wdata = 32'hA5A5A5A5; p0_func3 = 3'b010;
        @(negedge aclk);
        chk("rst_mid_gnt", 64'(p0_gnt), 64'(1));
        @(posedge aclk);
        #1 drop_req();
        chk("rst_mid_we_before", 64'(mem_write_en), 64'(1));
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_we_after", 64'(mem_write_en), 64'(0));
        chk("rst_mid_addr", 64'(mem_addr), 64'(0));
        @(posedge aclk);
        #2 aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            chk("rst_mid_no_resp", 64'({p0_rvalid, p1_rvalid, mem_write_en}), 64'(0));
        end

        // fixed priority: port 1 must break through once wait_cnt reaches 16
        @(posedge aclk);
        #1;
        b_p0_req = 1'b1;
        b_p1_req = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 80 && k < 10; cyc++) begin
            @(negedge aclk);
            if (b_p0_gnt || b_p1_gnt) begin
                st_port[k] = b_p1_gnt;
                st_cyc[k] = cyc;
                k++;
            end
        end
        @(posedge aclk);
        #1;
        b_p0_req = 1'b0;
        b_p1_req = 1'b0;
        chk("starve_count", 64'(k), 64'(10));
        if (k == 10) begin
            for (int i = 0; i < 10; i++) chk("starve_order", 64'(st_port[i]), 64'(exp_st[i]));
            chk("starve_first_p1_cycle", 64'(st_cyc[4]), 64'(16));
            chk("starve_second_p1_cycle", 64'(st_cyc[9]), 64'(36));
        end
        repeat (6) @(posedge aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
